// File: rtl/bottling_sequencer.sv
// bottling_sequencer: operator-key sequencer for the pill bottling counter.
// Turns start/pause/clear keys into the 2-bit run state and a pacing
// suspend signal. Targets are latched at start. The buzzer is timed in REPORT.
// Optional feature macro: BOTTLE_GAP_EN. When defined, each next-bottle pulse
// inserts a BOTTLE_GAP-cycle hold before pacing resumes.
//
//   state  | meaning
//   IDLE   | waiting for a valid start; counter held
//   RUN    | pacing pill drops, one permission per PILL_PERIOD cycles
//   PAUSE  | operator pause; pace and gap counters frozen
//   REPORT | all bottles done; alarm for ALARM_CYCLES, start returns to IDLE

module bottling_sequencer #(
  parameter int unsigned PILL_PERIOD  = 50,
  parameter int unsigned ALARM_CYCLES = 1000,
  parameter int unsigned BOTTLE_GAP   = 20
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_start,
  input  logic       in_pause,
  input  logic       in_clear,
  input  logic [5:0] in_target_bottle_num,
  input  logic [5:0] in_target_pill_num,
  input  logic       in_finish,
  input  logic       in_next_bottle,
  output logic [1:0] out_state,
  output logic       out_suspend,
  output logic [5:0] out_target_bottle_num,
  output logic [5:0] out_target_pill_num,
  output logic       out_alarm,
  output logic       out_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_REPORT = 2'b11
  } state_t;

  localparam logic [15:0] PACE_LAST  = 16'(PILL_PERIOD - 1);
  localparam logic [15:0] ALARM_LOAD = 16'(ALARM_CYCLES);

  // Key sampling registers and edge-detect history.
  logic start_q, start_d, pause_q, pause_d, clear_q, clear_d, finish_q, finish_d;
  logic start_prev_q, start_prev_d, pause_prev_q, pause_prev_d;
  // key_vld_q/hist_vld_q mask edges until the history reflects post-reset
  // key levels, so a key held through reset release is not seen as a press.
  logic key_vld_q, key_vld_d, hist_vld_q, hist_vld_d;
  logic start_edge, pause_edge;

  state_t      state_q, state_d;
  logic        suspend_q, suspend_d;
  logic [5:0]  tgt_bottle_q, tgt_bottle_d, tgt_pill_q, tgt_pill_d;
  logic        alarm_q, alarm_d;
  logic        err_q, err_d;
  logic [15:0] pace_q, pace_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] acnt_q, acnt_d;

`ifdef BOTTLE_GAP_EN
  localparam logic [15:0] GAP_LOAD = 16'(BOTTLE_GAP);
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^{in_next_bottle, 16'(BOTTLE_GAP)};
`endif

  // Key sampling: keys are registered once, then compared with their history.
  always_comb begin
    start_d      = in_start;
    pause_d      = in_pause;
    clear_d      = in_clear;
    finish_d     = in_finish;
    start_prev_d = start_q;
    pause_prev_d = pause_q;
    key_vld_d    = 1'b1;
    hist_vld_d   = key_vld_q;
    start_edge   = start_q & ~start_prev_q & hist_vld_q;
    pause_edge   = pause_q & ~pause_prev_q & hist_vld_q;
  end

  // Next-state, pacing, gap, alarm and latched-output logic.
  always_comb begin
    state_d      = state_q;
    pace_d       = pace_q;
    gap_d        = gap_q;
    acnt_d       = acnt_q;
    alarm_d      = alarm_q;
    err_d        = err_q;
    tgt_bottle_d = tgt_bottle_q;
    tgt_pill_d   = tgt_pill_q;

    if (clear_q) begin
      state_d = ST_IDLE;
      err_d   = 1'b0;
      alarm_d = 1'b0;
      acnt_d  = 16'd0;
      pace_d  = 16'd0;
      gap_d   = 16'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            if (in_target_bottle_num != 6'd0 && in_target_pill_num != 6'd0) begin
              state_d      = ST_RUN;
              tgt_bottle_d = in_target_bottle_num;
              tgt_pill_d   = in_target_pill_num;
              err_d        = 1'b0;
              pace_d       = 16'd0;
              gap_d        = 16'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (finish_q) begin
            state_d = ST_REPORT;
            alarm_d = 1'b1;
            acnt_d  = ALARM_LOAD;
            pace_d  = 16'd0;
            gap_d   = 16'd0;
          end else begin
            if (pause_edge) state_d = ST_PAUSE;
            // Pace advances on every RUN cycle, including the one that
            // pauses, so a resume continues exactly where counting stopped.
            if (gap_q != 16'd0) begin
              gap_d  = gap_q - 16'd1;
              pace_d = 16'd0;
            end else if (pace_q >= PACE_LAST) begin
              pace_d = 16'd0;
            end else begin
              pace_d = pace_q + 16'd1;
            end
`ifdef BOTTLE_GAP_EN
            if (in_next_bottle) begin
              gap_d  = GAP_LOAD;
              pace_d = 16'd0;
            end
`endif
          end
        end
        ST_PAUSE: begin
          if (pause_edge) state_d = ST_RUN;
        end
        ST_REPORT: begin
          acnt_d  = (acnt_q != 16'd0) ? acnt_q - 16'd1 : 16'd0;
          alarm_d = (acnt_d != 16'd0);
          if (start_edge) begin
            state_d = ST_IDLE;
            alarm_d = 1'b0;
            acnt_d  = 16'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Permission is decided from next-cycle state, so a pause landing on a
    // tick cycle suppresses that tick.
    suspend_d = !((state_d == ST_RUN) && (pace_d == PACE_LAST) && (gap_d == 16'd0));
  end

  // All registers, synchronous active-low reset.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      clear_q      <= 1'b0;
      finish_q     <= 1'b0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      key_vld_q    <= 1'b0;
      hist_vld_q   <= 1'b0;
      state_q      <= ST_IDLE;
      suspend_q    <= 1'b1;
      tgt_bottle_q <= 6'd0;
      tgt_pill_q   <= 6'd0;
      alarm_q      <= 1'b0;
      err_q        <= 1'b0;
      pace_q       <= 16'd0;
      gap_q        <= 16'd0;
      acnt_q       <= 16'd0;
    end else begin
      start_q      <= start_d;
      pause_q      <= pause_d;
      clear_q      <= clear_d;
      finish_q     <= finish_d;
      start_prev_q <= start_prev_d;
      pause_prev_q <= pause_prev_d;
      key_vld_q    <= key_vld_d;
      hist_vld_q   <= hist_vld_d;
      state_q      <= state_d;
      suspend_q    <= suspend_d;
      tgt_bottle_q <= tgt_bottle_d;
      tgt_pill_q   <= tgt_pill_d;
      alarm_q      <= alarm_d;
      err_q        <= err_d;
      pace_q       <= pace_d;
      gap_q        <= gap_d;
      acnt_q       <= acnt_d;
    end
  end

  assign out_state             = state_q;
  assign out_suspend           = suspend_q;
  assign out_target_bottle_num = tgt_bottle_q;
  assign out_target_pill_num   = tgt_pill_q;
  assign out_alarm             = alarm_q;
  assign out_err               = err_q;

endmodule

// File: tb/tb_bottling_sequencer.sv
// Directed bench for bottling_sequencer: PILL_PERIOD=5, ALARM_CYCLES=8,
// BOTTLE_GAP=3. Inputs driven and outputs sampled on the falling edge.

module tb_bottling_sequencer;

  logic       in_clk = 1'b0;
  logic       in_rst_n;
  logic       in_start, in_pause, in_clear, in_finish, in_next_bottle;
  logic [5:0] in_target_bottle_num, in_target_pill_num;
  logic [1:0] out_state;
  logic       out_suspend, out_alarm, out_err;
  logic [5:0] out_target_bottle_num, out_target_pill_num;

  int checks   = 0;
  int failures = 0;

  bottling_sequencer #(.PILL_PERIOD(5), .ALARM_CYCLES(8), .BOTTLE_GAP(3)) dut (
    .in_clk               (in_clk),
    .in_rst_n             (in_rst_n),
    .in_start             (in_start),
    .in_pause             (in_pause),
    .in_clear             (in_clear),
    .in_target_bottle_num (in_target_bottle_num),
    .in_target_pill_num   (in_target_pill_num),
    .in_finish            (in_finish),
    .in_next_bottle       (in_next_bottle),
    .out_state            (out_state),
    .out_suspend          (out_suspend),
    .out_target_bottle_num(out_target_bottle_num),
    .out_target_pill_num  (out_target_pill_num),
    .out_alarm            (out_alarm),
    .out_err              (out_err)
  );

  always #5 in_clk = ~in_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle key press; the response edge is one tick later.
  task automatic press_start();
    in_start = 1'b1; tick(1); in_start = 1'b0;
  endtask
  task automatic press_pause();
    in_pause = 1'b1; tick(1); in_pause = 1'b0;
  endtask
  task automatic press_clear();
    in_clear = 1'b1; tick(1); in_clear = 1'b0;
  endtask
  task automatic pulse_finish();
    in_finish = 1'b1; tick(1); in_finish = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   16'(out_state), 16'd0);
    check({tag, "_suspend"}, 16'(out_suspend), 16'd1);
    check({tag, "_tbottle"}, 16'(out_target_bottle_num), 16'd0);
    check({tag, "_tpill"},   16'(out_target_pill_num), 16'd0);
    check({tag, "_alarm"},   16'(out_alarm), 16'd0);
    check({tag, "_err"},     16'(out_err), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_s;
    in_rst_n = 1'b0;
    in_start = 1'b1;            // held through reset release
    in_pause = 1'b0; in_clear = 1'b0; in_finish = 1'b0; in_next_bottle = 1'b0;
    in_target_bottle_num = 6'd3; in_target_pill_num = 6'd0;
    tick(3);
    check_reset_values("rst");
    in_rst_n = 1'b1;
    tick(4);
    check("held_start_no_edge", 16'(out_state), 16'd0);
    in_start = 1'b0;
    tick(2);

    // Zero pill target rejected
    press_start(); tick(1);
    check("zero_tgt_state", 16'(out_state), 16'd0);
    check("zero_tgt_err", 16'(out_err), 16'd1);

    // Valid start
    in_target_pill_num = 6'd4;
    press_start(); tick(1);
    check("start_state", 16'(out_state), 16'd1);
    check("start_err", 16'(out_err), 16'd0);
    check("start_tbottle", 16'(out_target_bottle_num), 16'd3);
    check("start_tpill", 16'(out_target_pill_num), 16'd4);

    // Pacing: permission on RUN cycles 4, 9, 14
    for (int c = 0; c < 15; c++) begin
      exp_s = ((c % 5) == 4) ? 1'b0 : 1'b1;
      check($sformatf("pace_c%0d", c), 16'(out_suspend), 16'(exp_s));
      if (c == 7) in_target_pill_num = 6'd7;
      tick(1);
    end
    check("frozen_tpill_run", 16'(out_target_pill_num), 16'd4);
    in_target_pill_num = 6'd4;

    // Pause edge landing on the tick at cycle 19
    tick(2);                    // cycle 17
    in_pause = 1'b1; tick(1);   // cycle 18
    in_pause = 1'b0;
    check("pre_pause_state", 16'(out_state), 16'd1);
    check("pre_pause_susp", 16'(out_suspend), 16'd1);
    tick(1);                    // cycle 19: would have been a tick
    check("pause_state", 16'(out_state), 16'd2);
    check("pause_tick_suppressed", 16'(out_suspend), 16'd1);
    press_start(); tick(1);
    check("pause_ignores_start", 16'(out_state), 16'd2);

    // Resume: only the remaining pace cycle is left
    press_pause(); tick(1);
    check("resume_state", 16'(out_state), 16'd1);
    check("resume_tick", 16'(out_suspend), 16'd0);
    tick(1);
    check("resume_next_hold", 16'(out_suspend), 16'd1);
    tick(4);
    check("resume_period", 16'(out_suspend), 16'd0);

    // next-bottle pulse in a pace-0 cycle
    tick(1);
    in_next_bottle = 1'b1; tick(1); in_next_bottle = 1'b0;
    for (int k = 1; k <= 9; k++) begin
`ifdef BOTTLE_GAP_EN
      exp_s = (k == 8) ? 1'b0 : 1'b1;
`else
      exp_s = (k == 4 || k == 9) ? 1'b0 : 1'b1;
`endif
      check($sformatf("gap_k%0d", k), 16'(out_suspend), 16'(exp_s));
      tick(1);
    end

    // Finish -> REPORT, alarm exactly 8 cycles
    pulse_finish(); tick(1);
    check("report_state", 16'(out_state), 16'd3);
    check("report_susp", 16'(out_suspend), 16'd1);
    for (int r = 0; r < 10; r++) begin
      check($sformatf("alarm_r%0d", r), 16'(out_alarm), (r < 8) ? 16'd1 : 16'd0);
      tick(1);
    end
    press_start(); tick(1);
    check("report_to_idle", 16'(out_state), 16'd0);
    check("idle_tbottle", 16'(out_target_bottle_num), 16'd3);

    // Error cleared by clear
    in_target_bottle_num = 6'd0;
    press_start(); tick(1);
    check("zero_bottle_err", 16'(out_err), 16'd1);
    in_target_bottle_num = 6'd3;
    press_clear(); tick(1);
    check("clear_err", 16'(out_err), 16'd0);

    // Clear in PAUSE
    press_start(); tick(1);
    check("run2_state", 16'(out_state), 16'd1);
    press_pause(); tick(1);
    check("pause2_state", 16'(out_state), 16'd2);
    in_target_pill_num = 6'd9;
    press_clear(); tick(1);
    check("clear_pause_state", 16'(out_state), 16'd0);
    check("clear_pause_tpill", 16'(out_target_pill_num), 16'd4);
    in_target_pill_num = 6'd4;

    // Clear in REPORT cuts the alarm short
    press_start(); tick(1);
    pulse_finish(); tick(1);
    check("report2_state", 16'(out_state), 16'd3);
    check("report2_alarm", 16'(out_alarm), 16'd1);
    tick(2);
    press_clear(); tick(1);
    check("clear_report_state", 16'(out_state), 16'd0);
    check("clear_report_alarm", 16'(out_alarm), 16'd0);
    check("clear_report_tbottle", 16'(out_target_bottle_num), 16'd3);
    check("clear_report_tpill", 16'(out_target_pill_num), 16'd4);

    // Reset mid-RUN
    press_start(); tick(1);
    check("run3_state", 16'(out_state), 16'd1);
    tick(3);
    in_rst_n = 1'b0; tick(1);
    check_reset_values("midrst");
    in_rst_n = 1'b1;
    tick(3);
    check("post_rst_state", 16'(out_state), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
